// File: rtl/bit_permute_pipe.sv
// Registered valid/ready stage applying one of four bit permutations
// (pass, full reverse, in-group reverse, group swap) per transferred word.
module bit_permute_pipe #(
    parameter int N = 3,
    parameter int G = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2**N-1:0]   in_data,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2**N-1:0]   out_data,
    output logic [1:0]        out_mode,
    output logic [15:0]       xfer_cnt
);

    localparam int W  = 2**N;
    localparam int K  = 2**G;
    localparam int NG = W / K;

    generate
        if (G <= 0 || G >= N) begin : g_bad_group
            $error("bit_permute_pipe: G must satisfy 0 < G < N");
        end
    endgenerate

    logic [W-1:0] rev_w;
    logic [W-1:0] grev_w;
    logic [W-1:0] gswp_w;
    logic [W-1:0] perm_w;

    // Bit i sits at offset i%K inside group i/K.
    always_comb begin
        rev_w  = '0;
        grev_w = '0;
        gswp_w = '0;
        for (int i = 0; i < W; i++) begin
            rev_w[W-1-i]                      = in_data[i];
            grev_w[(i/K)*K + (K-1-(i%K))]     = in_data[i];
            gswp_w[(NG-1-(i/K))*K + (i%K)]    = in_data[i];
        end
    end

    always_comb begin
        perm_w = in_data;
        unique case (in_mode)
            2'b00: perm_w = in_data;
            2'b01: perm_w = rev_w;
            2'b10: perm_w = grev_w;
            2'b11: perm_w = gswp_w;
            default: perm_w = in_data;
        endcase
    end

    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [1:0]    out_mode_q,  out_mode_d;
    logic [15:0]   xfer_cnt_q,  xfer_cnt_d;
    logic          in_xfer;
    logic          out_xfer;

    // Ready is held low while reset is asserted so stimulus is ignored.
    assign in_ready = !reset && (!out_valid_q || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mode_d  = out_mode_q;
        xfer_cnt_d  = xfer_cnt_q + {15'd0, out_xfer};
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = perm_w;
            out_mode_d  = in_mode;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mode_q  <= 2'b00;
            xfer_cnt_q  <= 16'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule
